// File: rtl/single_cycle_cpu.sv
// Single-cycle 32-bit MIPS-subset core: fetch, decode, execute, memory and writeback in one clock.
// Define CPU_SHIFT_EN to build the sll/srl barrel shifter; otherwise those functs decode as nop.
module single_cycle_cpu #(
  parameter int bit_size = 32,
  parameter int mem_size = 16
) (
  input  logic                clk,
  input  logic                rst,
  output logic [mem_size-1:0] IM_Address,
  input  logic [bit_size-1:0] Instruction,
  output logic [mem_size-1:0] DM_Address,
  output logic                DM_enable,
  output logic [bit_size-1:0] DM_Write_Data,
  input  logic [bit_size-1:0] DM_Read_Data
);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  logic [bit_size-1:0] pc;
  logic [bit_size-1:0] regs [32];

  logic [5:0]          opcode;
  logic [5:0]          funct;
  logic [4:0]          rs;
  logic [4:0]          rt;
  logic [4:0]          rd;
  logic [15:0]         imm;
  logic [bit_size-1:0] rs_val;
  logic [bit_size-1:0] rt_val;
  logic [bit_size-1:0] sext_imm;
  logic [bit_size-1:0] zext_imm;
  logic [bit_size-1:0] pc_plus4;
  logic [bit_size-1:0] branch_target;
  logic [bit_size-1:0] jump_target;
  logic [bit_size-1:0] next_pc;
  logic [bit_size-1:0] alu_result;
  logic [bit_size-1:0] wr_data;
  logic [4:0]          wr_addr;
  logic                reg_we;
  logic                mem_we;

  assign opcode = Instruction[31:26];
  assign rs     = Instruction[25:21];
  assign rt     = Instruction[20:16];
  assign rd     = Instruction[15:11];
  assign funct  = Instruction[5:0];
  assign imm    = Instruction[15:0];

  assign rs_val   = (rs == 5'd0) ? '0 : regs[rs];
  assign rt_val   = (rt == 5'd0) ? '0 : regs[rt];
  assign sext_imm = {{(bit_size-16){imm[15]}}, imm};
  assign zext_imm = {{(bit_size-16){1'b0}}, imm};

  assign pc_plus4      = pc + bit_size'(4);
  assign branch_target = pc_plus4 + (sext_imm << 2);
  assign jump_target   = {pc_plus4[bit_size-1:bit_size-4], Instruction[25:0], 2'b00};

  // Load and store addresses come out of the default ALU path (rs + sext(imm)).
  always_comb begin
    reg_we     = 1'b0;
    mem_we     = 1'b0;
    wr_addr    = rt;
    alu_result = rs_val + sext_imm;
    next_pc    = pc_plus4;
    case (opcode)
      OP_RTYPE: begin
        wr_addr = rd;
        case (funct)
          FN_ADD: begin alu_result = rs_val + rt_val; reg_we = 1'b1; end
          FN_SUB: begin alu_result = rs_val - rt_val; reg_we = 1'b1; end
          FN_AND: begin alu_result = rs_val & rt_val; reg_we = 1'b1; end
          FN_OR:  begin alu_result = rs_val | rt_val; reg_we = 1'b1; end
          FN_SLT: begin
            alu_result = {{(bit_size-1){1'b0}}, $signed(rs_val) < $signed(rt_val)};
            reg_we     = 1'b1;
          end
`ifdef CPU_SHIFT_EN
          FN_SLL: begin alu_result = rt_val << Instruction[10:6]; reg_we = 1'b1; end
          FN_SRL: begin alu_result = rt_val >> Instruction[10:6]; reg_we = 1'b1; end
`endif
          FN_JR:  next_pc = rs_val;
          default: ;
        endcase
      end
      OP_ADDI: reg_we = 1'b1;
      OP_SLTI: begin
        alu_result = {{(bit_size-1){1'b0}}, $signed(rs_val) < $signed(sext_imm)};
        reg_we     = 1'b1;
      end
      OP_ANDI: begin alu_result = rs_val & zext_imm; reg_we = 1'b1; end
      OP_ORI:  begin alu_result = rs_val | zext_imm; reg_we = 1'b1; end
      OP_LW:   reg_we = 1'b1;
      OP_SW:   mem_we = 1'b1;
      OP_BEQ:  if (rs_val == rt_val) next_pc = branch_target;
      OP_BNE:  if (rs_val != rt_val) next_pc = branch_target;
      OP_J:    next_pc = jump_target;
      OP_JAL: begin
        next_pc = jump_target;
        wr_addr = 5'd31;
        reg_we  = 1'b1;
      end
      default: ;
    endcase
    wr_data = alu_result;
    if (opcode == OP_LW) wr_data = DM_Read_Data;
    if (opcode == OP_JAL) wr_data = pc_plus4;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      pc <= next_pc;
      if (reg_we && wr_addr != 5'd0) regs[wr_addr] <= wr_data;
    end
  end

  assign IM_Address    = pc[mem_size+1:2];
  assign DM_Address    = alu_result[mem_size+1:2];
  assign DM_Write_Data = rt_val;
  assign DM_enable     = mem_we & rst;

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Bench for single_cycle_cpu: directed program plus random program, checked in lockstep
// against an instruction-level model of the ISA held in this file.
module tb_single_cycle_cpu;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] im_address;
  logic [31:0] instruction;
  logic [15:0] dm_address;
  logic        dm_enable;
  logic [31:0] dm_write_data;
  logic [31:0] dm_read_data;

  logic [31:0] im [1024];
  logic [31:0] dm [8192];

  logic [31:0] m_reg [32];
  logic [31:0] m_pc;
  logic [31:0] m_dm [8192];

  int check_count = 0;
  int error_count = 0;

  single_cycle_cpu #(.bit_size(32), .mem_size(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .IM_Address    (im_address),
    .Instruction   (instruction),
    .DM_Address    (dm_address),
    .DM_enable     (dm_enable),
    .DM_Write_Data (dm_write_data),
    .DM_Read_Data  (dm_read_data)
  );

  always #5 clk = ~clk;

  assign instruction  = im[im_address[9:0]];
  assign dm_read_data = dm[dm_address[12:0]];

  always @(posedge clk) if (dm_enable) dm[dm_address[12:0]] <= dm_write_data;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] enc_r(int funct, int rs, int rt, int rd, int shamt);
    return {6'h00, rs[4:0], rt[4:0], rd[4:0], shamt[4:0], funct[5:0]};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {op[5:0], rs[4:0], rt[4:0], imm[15:0]};
  endfunction

  function automatic logic [31:0] enc_j(int op, int target);
    return {op[5:0], target[25:0]};
  endfunction

  task automatic model_reset();
    m_pc = 32'h0;
    for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
  endtask

  // Executes one instruction of the ISA on the model state and reports any store it makes.
  task automatic model_step(output logic st_we, output logic [31:0] st_addr, output logic [31:0] st_data);
    logic [31:0] ins, a, b, se, ze, npc, wval, ea;
    logic [4:0]  wdst;
    logic        wen;
    ins  = im[m_pc[11:2]];
    a    = m_reg[ins[25:21]];
    b    = m_reg[ins[20:16]];
    se   = {{16{ins[15]}}, ins[15:0]};
    ze   = {16'h0, ins[15:0]};
    ea   = a + se;
    npc  = m_pc + 32'd4;
    wen  = 1'b0;
    wdst = ins[20:16];
    wval = 32'h0;
    st_we = 1'b0; st_addr = 32'h0; st_data = 32'h0;
    case (ins[31:26])
      6'h00: begin
        wdst = ins[15:11];
        wen  = 1'b1;
        case (ins[5:0])
          6'h20: wval = a + b;
          6'h22: wval = a - b;
          6'h24: wval = a & b;
          6'h25: wval = a | b;
          6'h2A: wval = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
`ifdef CPU_SHIFT_EN
          6'h00: wval = b << ins[10:6];
          6'h02: wval = b >> ins[10:6];
`endif
          6'h08: begin wen = 1'b0; npc = a; end
          default: wen = 1'b0;
        endcase
      end
      6'h08: begin wen = 1'b1; wval = a + se; end
      6'h0A: begin wen = 1'b1; wval = ($signed(a) < $signed(se)) ? 32'd1 : 32'd0; end
      6'h0C: begin wen = 1'b1; wval = a & ze; end
      6'h0D: begin wen = 1'b1; wval = a | ze; end
      6'h23: begin wen = 1'b1; wval = m_dm[ea[14:2]]; end
      6'h2B: begin
        st_we = 1'b1; st_addr = ea; st_data = b;
        m_dm[ea[14:2]] = b;
      end
      6'h04: if (a == b) npc = m_pc + 32'd4 + (se << 2);
      6'h05: if (a != b) npc = m_pc + 32'd4 + (se << 2);
      6'h02: npc = {npc[31:28], ins[25:0], 2'b00};
      6'h03: begin
        wen = 1'b1; wdst = 5'd31; wval = m_pc + 32'd4;
        npc = {npc[31:28], ins[25:0], 2'b00};
      end
      default: ;
    endcase
    if (wen && wdst != 5'd0) m_reg[wdst] = wval;
    m_pc = npc;
  endtask

  // Called at a falling edge; runs the DUT and the model side by side for the given cycles.
  task automatic applyStimulus(input int cycles, input bit directed);
    logic        we;
    logic [31:0] addr, data;
    logic [15:0] prev;
    for (int c = 0; c < cycles; c++) begin
      prev = m_pc[17:2];
      model_step(we, addr, data);
      checkOutput("dm_enable", {31'h0, dm_enable}, {31'h0, we});
      if (we) begin
        checkOutput("dm_address", {16'h0, dm_address}, {16'h0, addr[17:2]});
        checkOutput("dm_write_data", dm_write_data, data);
      end
      @(posedge clk);
      #1;
      checkOutput("im_address", {16'h0, im_address}, {16'h0, m_pc[17:2]});
      if (directed) begin
        if (c == 0) checkOutput("first_fetch", {16'h0, im_address}, 32'd1);
        case (prev)
          16'd20: checkOutput("beq_taken", {16'h0, im_address}, 32'd24);
          16'd24: checkOutput("bne_not_taken", {16'h0, im_address}, 32'd25);
          16'd27: checkOutput("jal_target", {16'h0, im_address}, 32'd40);
          16'd40: checkOutput("jr_return", {16'h0, im_address}, 32'd28);
          16'd44: checkOutput("j_target", {16'h0, im_address}, 32'd51);
          default: ;
        endcase
      end
      @(negedge clk);
    end
  endtask

  task automatic load_directed();
    for (int i = 0; i < 1024; i++) im[i] = 32'h0;
    im[0]  = enc_i('h08, 0, 1, 5);
    im[1]  = enc_i('h08, 0, 2, -3);
    im[2]  = enc_r('h20, 1, 2, 3, 0);
    im[3]  = enc_r('h22, 1, 2, 4, 0);
    im[4]  = enc_r('h24, 1, 2, 5, 0);
    im[5]  = enc_r('h25, 1, 2, 6, 0);
    im[6]  = enc_r('h2A, 2, 1, 7, 0);
    for (int k = 0; k < 5; k++) im[7+k] = enc_i('h2B, 0, 3+k, 4*k);
    im[12] = enc_i('h0D, 0, 8, 'hFFFF);
    im[13] = enc_i('h0C, 8, 9, 'h00F0);
    im[14] = enc_i('h0A, 2, 10, 0);
    im[15] = enc_i('h2B, 0, 8, 40);
    im[16] = enc_i('h2B, 0, 9, 44);
    im[17] = enc_i('h2B, 0, 10, 48);
    im[18] = enc_i('h23, 0, 11, 40);
    im[19] = enc_i('h2B, 0, 11, 52);
    im[20] = enc_i('h04, 1, 1, 3);
    for (int k = 21; k < 24; k++) im[k] = enc_i('h08, 0, 20, 1);
    im[24] = enc_i('h05, 1, 1, 3);
    im[25] = enc_i('h08, 0, 0, 7);
    im[26] = enc_i('h2B, 0, 0, 56);
    im[27] = enc_j('h03, 40);
    im[28] = enc_i('h2B, 0, 31, 60);
    im[29] = enc_j('h02, 44);
    im[40] = enc_r('h08, 31, 0, 0, 0);
    im[44] = enc_j('h02, 51);
    for (int k = 45; k < 51; k++) im[k] = enc_i('h08, 0, 21, 1);
    im[51] = enc_i('h2B, 0, 1, 64);
    im[52] = enc_j('h02, 52);
  endtask

  function automatic logic [31:0] rand_instr(int pos);
    int fl [5] = '{'h20, 'h22, 'h24, 'h25, 'h2A};
    int rs = int'($urandom_range(0, 15));
    int rt = int'($urandom_range(0, 15));
    int rd = int'($urandom_range(0, 15));
    int imm = int'($urandom_range(0, 65535));
    int off = 4 * int'($urandom_range(0, 255));
    case ($urandom_range(0, 13))
      0, 1:    return enc_r(fl[$urandom_range(0, 4)], rs, rt, rd, 0);
      2:       return enc_r(2 * int'($urandom_range(0, 1)), rs, rt, rd, int'($urandom_range(0, 31)));
      3:       return enc_r('h3F, rs, rt, rd, 0);
      4:       return enc_i('h08, rs, rt, imm);
      5:       return enc_i('h0A, rs, rt, imm);
      6:       return enc_i('h0C, rs, rt, imm);
      7:       return enc_i('h0D, rs, rt, imm);
      8:       return enc_i('h23, 0, rt, off);
      9:       return enc_i('h2B, 0, rt, off);
      10:      return enc_i('h04, rs % 4, rt % 4, int'($urandom_range(0, 3)));
      11:      return enc_i('h05, rs % 4, rt % 4, int'($urandom_range(0, 3)));
      12:      return enc_j(2 + int'($urandom_range(0, 1)), pos + int'($urandom_range(1, 4)));
      default: return enc_i('h3F, rs, rt, imm);
    endcase
  endfunction

  int dir_idx [12] = '{0, 1, 2, 3, 4, 10, 11, 12, 13, 14, 15, 16};
  logic [31:0] dir_exp [12] = '{32'h2, 32'h8, 32'h5, 32'hFFFFFFFD, 32'h1, 32'h0000FFFF,
                                32'h000000F0, 32'h1, 32'h0000FFFF, 32'h0, 32'd112, 32'h5};

  initial begin
    rst = 1'b0;
    for (int i = 0; i < 8192; i++) begin
      dm[i]   = 32'h0;
      m_dm[i] = 32'h0;
    end
    load_directed();
    #1;
    checkOutput("reset_im_address", {16'h0, im_address}, 32'h0);
    checkOutput("reset_dm_enable", {31'h0, dm_enable}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("reset_hold_im_address", {16'h0, im_address}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    applyStimulus(40, 1'b1);
    for (int k = 0; k < 12; k++) checkOutput("directed_dm", dm[dir_idx[k]], dir_exp[k]);

    // Reset arrives between edges while the core is running.
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    checkOutput("async_reset_im_address", {16'h0, im_address}, 32'h0);
    checkOutput("async_reset_dm_enable", {31'h0, dm_enable}, 32'h0);
    for (int i = 0; i < 1024; i++) im[i] = (i < 200) ? rand_instr(i) : enc_j('h02, i);
    for (int i = 0; i < 256; i++) begin
      dm[i]   = $urandom;
      m_dm[i] = dm[i];
    end
    @(posedge clk);
    #1;
    checkOutput("reset_hold2_im_address", {16'h0, im_address}, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    applyStimulus(300, 1'b0);
    for (int i = 0; i < 256; i++) checkOutput("random_dm", dm[i], m_dm[i]);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
